// File: rtl/sync_deframer.sv
// Receive deframer: hunts for the sync marker, checks frame length and padding,
// and unpacks 32-bit payload words into a big-endian byte stream.
module sync_deframer #(
    parameter logic [31:0] SYNC_MARKER  = 32'h1ACFFC1D,
    parameter int unsigned PAYLOAD_LEN  = 255,
    parameter logic [7:0]  PADDING_BYTE = 8'hAC
) (
    input  logic        core_clk,
    input  logic        rst_n,
    input  logic [31:0] s_axis_input_tdata,
    input  logic        s_axis_input_tvalid,
    input  logic        s_axis_input_tlast,
    output logic        s_axis_input_tready,
    output logic [7:0]  m_axis_output_tdata,
    output logic        m_axis_output_tvalid,
    output logic        m_axis_output_tlast,
    input  logic        m_axis_output_tready,
    output logic        frame_ok,
    output logic        sync_err,
    output logic        len_err,
    output logic        pad_err,
    output logic [15:0] frame_cnt,
    output logic [15:0] err_cnt
);

    localparam int unsigned PADDING_LEN = (4 - ((4 + PAYLOAD_LEN) % 4)) % 4;
    localparam int unsigned FRAME_WORDS = (4 + PAYLOAD_LEN + PADDING_LEN) / 4;
    localparam int unsigned IDX_W       = $clog2(FRAME_WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_WORDS - 1);
    localparam logic [2:0]       LAST_REM = 3'(4 - PADDING_LEN);

    typedef enum logic {
        HUNT,
        PAYLOAD
    } state_t;

    state_t           state_q;
    logic [IDX_W-1:0] idx_q;
    logic [31:0]      hold_q;
    logic [2:0]       rem_q;
    logic             last_q;
    logic             rdy_en_q;
    logic             frame_ok_q;
    logic             sync_err_q;
    logic             len_err_q;
    logic             pad_err_q;
    logic [15:0]      frame_cnt_q;
    logic [15:0]      err_cnt_q;

    logic accept;
    logic out_fire;
    logic pad_bad;

    // rdy_en_q keeps tready low while reset is asserted even though rem is 0
    assign s_axis_input_tready  = rdy_en_q &&
                                  ((rem_q == 3'd0) || ((rem_q == 3'd1) && m_axis_output_tready));
    assign accept               = s_axis_input_tvalid && s_axis_input_tready;
    assign m_axis_output_tvalid = (rem_q != 3'd0);
    assign m_axis_output_tdata  = hold_q[31:24];
    assign m_axis_output_tlast  = last_q && (rem_q == 3'd1);
    assign out_fire             = m_axis_output_tvalid && m_axis_output_tready;

    assign frame_ok  = frame_ok_q;
    assign sync_err  = sync_err_q;
    assign len_err   = len_err_q;
    assign pad_err   = pad_err_q;
    assign frame_cnt = frame_cnt_q;
    assign err_cnt   = err_cnt_q;

    // Padding occupies the low byte lanes of the final word
    always_comb begin
        pad_bad = 1'b0;
        for (int unsigned i = 0; i < PADDING_LEN; i++) begin
            if (s_axis_input_tdata[8*i +: 8] != PADDING_BYTE) begin
                pad_bad = 1'b1;
            end
        end
    end

    always_ff @(posedge core_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= HUNT;
            idx_q       <= '0;
            hold_q      <= '0;
            rem_q       <= '0;
            last_q      <= 1'b0;
            rdy_en_q    <= 1'b0;
            frame_ok_q  <= 1'b0;
            sync_err_q  <= 1'b0;
            len_err_q   <= 1'b0;
            pad_err_q   <= 1'b0;
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            rdy_en_q   <= 1'b1;
            frame_ok_q <= 1'b0;
            sync_err_q <= 1'b0;
            len_err_q  <= 1'b0;
            pad_err_q  <= 1'b0;

            if (out_fire) begin
                hold_q <= {hold_q[23:0], 8'h00};
                rem_q  <= rem_q - 3'd1;
            end

            // A load only happens once the last held byte is leaving, so it overrides the shift
            if (accept) begin
                unique case (state_q)
                    HUNT: begin
                        if ((s_axis_input_tdata == SYNC_MARKER) && !s_axis_input_tlast) begin
                            state_q <= PAYLOAD;
                            idx_q   <= IDX_W'(1);
                        end else begin
                            sync_err_q <= 1'b1;
                        end
                    end
                    PAYLOAD: begin
                        hold_q <= s_axis_input_tdata;
                        idx_q  <= idx_q + IDX_W'(1);
                        if (idx_q == LAST_IDX) begin
                            rem_q     <= LAST_REM;
                            last_q    <= 1'b1;
                            state_q   <= HUNT;
                            idx_q     <= '0;
                            pad_err_q <= pad_bad;
                            len_err_q <= !s_axis_input_tlast;
                            if (s_axis_input_tlast && !pad_bad) begin
                                frame_ok_q  <= 1'b1;
                                frame_cnt_q <= frame_cnt_q + 16'd1;
                            end else begin
                                err_cnt_q <= err_cnt_q + 16'd1;
                            end
                        end else begin
                            rem_q  <= 3'd4;
                            last_q <= s_axis_input_tlast;
                            if (s_axis_input_tlast) begin
                                len_err_q <= 1'b1;
                                err_cnt_q <= err_cnt_q + 16'd1;
                                state_q   <= HUNT;
                                idx_q     <= '0;
                            end
                        end
                    end
                    default: state_q <= HUNT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sync_deframer.sv
// Randomised scoreboard bench for sync_deframer: a frame-level reference model
// fills the expected byte queue, a negedge monitor pops and compares.
module tb_sync_deframer;

    localparam logic [31:0] MARK = 32'h1ACFFC1D;
    localparam int FW = 65;

    typedef struct packed {
        logic        l;
        logic [31:0] d;
    } word_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] s_tdata = '0;
    logic        s_tvalid = 1'b0;
    logic        s_tlast = 1'b0;
    logic        s_tready;
    logic [7:0]  m_tdata;
    logic        m_tvalid;
    logic        m_tlast;
    logic        m_tready = 1'b1;
    logic        frame_ok, sync_err, len_err, pad_err;
    logic [15:0] frame_cnt, err_cnt;

    sync_deframer #(
        .SYNC_MARKER (32'h1ACFFC1D),
        .PAYLOAD_LEN (255),
        .PADDING_BYTE(8'hAC)
    ) dut (
        .core_clk            (clk),
        .rst_n               (rst_n),
        .s_axis_input_tdata  (s_tdata),
        .s_axis_input_tvalid (s_tvalid),
        .s_axis_input_tlast  (s_tlast),
        .s_axis_input_tready (s_tready),
        .m_axis_output_tdata (m_tdata),
        .m_axis_output_tvalid(m_tvalid),
        .m_axis_output_tlast (m_tlast),
        .m_axis_output_tready(m_tready),
        .frame_ok            (frame_ok),
        .sync_err            (sync_err),
        .len_err             (len_err),
        .pad_err             (pad_err),
        .frame_cnt           (frame_cnt),
        .err_cnt             (err_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    word_t      stim[$];
    logic [8:0] exp_q[$];
    int e_ok = 0, e_sync = 0, e_len = 0, e_pad = 0, e_err = 0;
    int o_ok = 0, o_sync = 0, o_len = 0, o_pad = 0;
    bit chk_en = 1'b1;
    bit rand_rdy = 1'b0;
    bit gaps = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    // Monitor: outputs are stable at negedge; a byte shown with ready=1 is consumed at the next posedge
    initial begin
        bit         prev_stall = 1'b0;
        logic [7:0] pdt = '0;
        logic       plt = 1'b0;
        forever begin
            bit         r;
            logic       v, lt;
            logic [7:0] dt;
            logic [8:0] e;
            @(negedge clk);
            v  = m_tvalid;
            dt = m_tdata;
            lt = m_tlast;
            if (rst_n && chk_en && prev_stall) begin
                check("hold_valid", {31'd0, v}, 32'd1);
                check("hold_data_last", {23'd0, lt, dt}, {23'd0, plt, pdt});
            end
            r = rand_rdy ? ($urandom_range(0, 2) != 0) : 1'b1;
            m_tready = r;
            if (rst_n && chk_en && v && r) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_byte", {23'd0, lt, dt}, 32'h1FF);
                end else begin
                    e = exp_q.pop_front();
                    check("byte", {23'd0, lt, dt}, {23'd0, e});
                end
            end
            prev_stall = v && !r;
            pdt = dt;
            plt = lt;
            if (rst_n) begin
                o_ok   += int'(frame_ok);
                o_sync += int'(sync_err);
                o_len  += int'(len_err);
                o_pad  += int'(pad_err);
            end
        end
    end

    // Reference model: walks the word list frame by frame using the framing rules
    task automatic model();
        int i = 0;
        while (i < stim.size()) begin
            word_t w = stim[i];
            i++;
            if (w.d == MARK && !w.l) begin
                for (int k = 1; k < FW && i < stim.size(); k++) begin
                    int nb;
                    w = stim[i];
                    i++;
                    nb = (k < FW - 1) ? 4 : 3;
                    for (int j = 0; j < nb; j++) begin
                        bit lst = (j == nb - 1) && (w.l || k == FW - 1);
                        exp_q.push_back({lst, w.d[31 - 8*j -: 8]});
                    end
                    if (k < FW - 1) begin
                        if (w.l) begin
                            e_len++;
                            e_err++;
                            break;
                        end
                    end else begin
                        bit pok = (w.d[7:0] == 8'hAC);
                        if (!pok) e_pad++;
                        if (!w.l) e_len++;
                        if (w.l && pok) e_ok++;
                        else e_err++;
                    end
                end
            end else begin
                e_sync++;
            end
        end
    endtask

    task automatic make_frame(input int trunc, input bit nolast, input logic [7:0] pad, input bit rnd);
        logic [7:0] pl[255];
        for (int n = 0; n < 255; n++) pl[n] = rnd ? 8'($urandom) : 8'(n);
        stim.push_back('{l: 1'b0, d: MARK});
        for (int k = 1; k < FW; k++) begin
            word_t w;
            if (k < FW - 1) w.d = {pl[4*k-4], pl[4*k-3], pl[4*k-2], pl[4*k-1]};
            else            w.d = {pl[252], pl[253], pl[254], pad};
            w.l = (k == trunc) || (k == FW - 1 && !nolast);
            stim.push_back(w);
            if (k == trunc) break;
        end
    endtask

    task automatic send(input word_t w);
        int budget = 0;
        if (gaps) begin
            while ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                s_tvalid = 1'b0;
            end
        end
        forever begin
            @(negedge clk);
            s_tvalid = 1'b1;
            s_tdata  = w.d;
            s_tlast  = w.l;
            #1;
            if (s_tready) begin
                @(posedge clk);
                break;
            end
            budget++;
            if (budget > 1000) begin
                check("input_accept_timeout", 32'd0, 32'd1);
                break;
            end
        end
    endtask

    task automatic drain();
        int budget = 0;
        @(negedge clk);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        while (exp_q.size() != 0 && budget < 5000) begin
            @(negedge clk);
            budget++;
        end
        if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 32'd0);
        repeat (4) @(negedge clk);
    endtask

    task automatic run(input string name);
        model();
        foreach (stim[i]) send(stim[i]);
        stim.delete();
        drain();
        check({name, "_frame_ok"}, o_ok, e_ok);
        check({name, "_sync_err"}, o_sync, e_sync);
        check({name, "_len_err"}, o_len, e_len);
        check({name, "_pad_err"}, o_pad, e_pad);
        check({name, "_frame_cnt"}, {16'd0, frame_cnt}, 32'(e_ok & 16'hFFFF));
        check({name, "_err_cnt"}, {16'd0, err_cnt}, 32'(e_err & 16'hFFFF));
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_tready"}, {31'd0, s_tready}, 32'd0);
        check({name, "_mvalid_tlast"}, {30'd0, m_tvalid, m_tlast}, 32'd0);
        check({name, "_mdata"}, {24'd0, m_tdata}, 32'd0);
        check({name, "_pulses"}, {28'd0, frame_ok, sync_err, len_err, pad_err}, 32'd0);
        check({name, "_counters"}, {frame_cnt, err_cnt}, 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        make_frame(0, 1'b0, 8'hAC, 1'b0);
        run("good");

        stim.push_back('{l: 1'b0, d: 32'hDEADBEEF});
        stim.push_back('{l: 1'b0, d: 32'h00000000});
        make_frame(0, 1'b0, 8'hAC, 1'b0);
        run("junk");

        rand_rdy = 1'b1;
        gaps = 1'b1;
        make_frame(0, 1'b0, 8'hAC, 1'b0);
        run("stall");

        make_frame(10, 1'b0, 8'hAC, 1'b0);
        make_frame(0, 1'b0, 8'hAC, 1'b0);
        run("trunc");

        make_frame(0, 1'b0, 8'h00, 1'b0);
        run("badpad");

        make_frame(0, 1'b1, 8'h5A, 1'b0);
        make_frame(0, 1'b1, 8'hAC, 1'b0);
        make_frame(0, 1'b0, 8'hAC, 1'b0);
        run("nolast");

        for (int it = 0; it < 8; it++) begin
            int nj = $urandom_range(0, 2);
            int kind = $urandom_range(0, 4);
            logic [7:0] bp = 8'($urandom);
            for (int j = 0; j < nj; j++) begin
                word_t w;
                w.d = $urandom;
                w.l = 1'($urandom);
                if ($urandom_range(0, 3) == 0) begin
                    w.d = MARK;
                    w.l = 1'b1;
                end
                stim.push_back(w);
            end
            if (bp == 8'hAC) bp = 8'h00;
            case (kind)
                0: make_frame(0, 1'b0, 8'hAC, 1'b1);
                1: make_frame($urandom_range(1, FW - 2), 1'b0, 8'hAC, 1'b1);
                2: make_frame(0, 1'b0, bp, 1'b1);
                3: make_frame(0, 1'b1, 8'hAC, 1'b1);
                default: make_frame(0, 1'b1, bp, 1'b1);
            endcase
        end
        run("random");

        // Abort a frame mid-payload with reset; nothing of it may be checked afterwards
        chk_en = 1'b0;
        make_frame(30, 1'b0, 8'hAC, 1'b0);
        void'(stim.pop_back());
        foreach (stim[i]) send(stim[i]);
        stim.delete();
        @(negedge clk);
        s_tvalid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        repeat (2) @(negedge clk);
        check_reset_outputs("midrst_hold");
        exp_q.delete();
        e_ok = 0; e_sync = 0; e_len = 0; e_pad = 0; e_err = 0;
        o_ok = 0; o_sync = 0; o_len = 0; o_pad = 0;
        rst_n = 1'b1;
        chk_en = 1'b1;
        make_frame(0, 1'b0, 8'hAC, 1'b0);
        run("postrst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #20ms;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/sync_deframer.md
Name: sync_deframer

Overview:
- Receive-side counterpart of the transmit framer in the tx_to_rx loop.
- Consumes the 32-bit AXI-Stream of framed words. Each frame is 65 words: a 32-bit sync marker, 255 payload bytes, then 1 padding byte, with tlast on the final word.
- Validates the marker, the frame length and the padding. Unpacks the payload into an 8-bit AXI-Stream, big-endian (bits [31:24] first), and discards marker and padding.
- Reports per-frame status pulses and counters for loopback checking.

Parameters:
- SYNC_MARKER, 32'h1ACFFC1D, marker expected in word 0 of each frame.
- PAYLOAD_LEN, 255, payload bytes per frame.
- PADDING_BYTE, 8'hAC, expected value of every padding byte.
- PADDING_LEN, derived = (4-((4+PAYLOAD_LEN)%4))%4 (=1), localparam.
- FRAME_WORDS, derived = (4+PAYLOAD_LEN+PADDING_LEN)/4 (=65), localparam.

Ports:
- core_clk  in  1  single clock for the whole block.
- rst_n  in  1  reset, asynchronous, active-low.
- s_axis_input_tdata  in  32  framed word.
- s_axis_input_tvalid  in  1  input word valid.
- s_axis_input_tlast  in  1  input end of frame.
- s_axis_input_tready  out  1  input word accepted when tvalid & tready.
- m_axis_output_tdata  out  8  payload byte.
- m_axis_output_tvalid  out  1  output byte valid.
- m_axis_output_tlast  out  1  last byte of a (possibly truncated) frame.
- m_axis_output_tready  in  1  downstream ready.
- frame_ok  out  1  1-cycle pulse: frame completed with correct length and padding.
- sync_err  out  1  1-cycle pulse per word discarded while hunting.
- len_err  out  1  1-cycle pulse on a tlast mismatch.
- pad_err  out  1  1-cycle pulse on a padding mismatch.
- frame_cnt  out  16  count of frame_ok pulses, wraps 16'hFFFF->0.
- err_cnt  out  16  count of len_err or pad_err events (one increment per frame), wraps.

Behaviour:
- Reset (async, rst_n=0):
  - State HUNT; word index 0; unpack buffer empty.
  - All outputs 0 (s_axis_input_tready rises only after reset is released); counters 0.
  - A partial frame in flight is dropped; no tlast is emitted for it.
- Unpacker:
  - 32-bit hold register plus a remaining-byte count rem, 0..4.
  - m_tvalid = (rem != 0); m_tdata = current byte, MSB first.
  - m_tdata and m_tlast are held stable while valid & !ready.
  - s_tready = (rem==0) || (rem==1 && m_tready): a combinational path from m_tready is allowed.
  - Sustained rate is 1 byte/cycle with no bubbles.
  - First byte of an accepted payload word is valid the cycle after acceptance.
- State HUNT:
  - s_tready=1 when rem==0.
  - Accepted word == SYNC_MARKER with tlast=0 -> PAYLOAD, word index 1, nothing output.
  - Any other accepted word -> sync_err pulse, word dropped, stay in HUNT.
  - Marker carrying tlast=1 counts as a non-marker: sync_err.
- State PAYLOAD:
  - Each accepted word loads the unpacker and increments the word index.
  - Word index 1..FRAME_WORDS-2: rem=4.
  - Word index FRAME_WORDS-1: rem = 4-PADDING_LEN. Padding bytes (low lanes) are compared to PADDING_BYTE; any mismatch -> pad_err pulse on acceptance. Padding is never output.
  - m_tlast is set on the last loaded byte of the last word.
- Frame end:
  - tlast=1 on word FRAME_WORDS-1 with padding OK -> frame_ok pulse and frame_cnt++ on acceptance, then HUNT.
  - Early tlast (word index < FRAME_WORDS-1): all 4 bytes of that word are output, m_tlast on its 4th byte, len_err pulse, then HUNT.
  - No tlast on word FRAME_WORDS-1: len_err pulse, m_tlast is still emitted on payload byte 254, then HUNT. The next word is hunted.
  - len_err and pad_err in the same frame: both pulses fire, err_cnt increments once.
- Status pulses:
  - All status pulses are registered and fire the cycle after the triggering acceptance.
  - A new frame's marker may be accepted while the previous word's last bytes drain; the rem==1 rule makes this overlap-free.

Test Plan:
- Frame of marker + bytes 00..FE + pad AC (65 words, tlast on word 64), m_tready=1 -> 255 bytes 00..FE in order, tlast only on FE, one frame_ok, frame_cnt=1, no error pulses.
- Words 0xDEADBEEF, 0x00000000, then the good frame -> two sync_err pulses, payload correct, frame_ok=1.
- Good frame with m_tready toggling pseudo-randomly and s_tvalid gapped -> byte sequence identical, no data change while valid&!ready.
- tlast on word 10 -> 40 bytes (00..27) output, tlast on 0x27, len_err=1, err_cnt=1; a following good frame gives frame_ok.
- Padding byte 0x00 -> all 255 bytes correct, pad_err=1, no frame_ok, err_cnt=1.
- rst_n low at payload word 30 then a good frame -> all outputs 0 during reset, no stray tlast, the next frame decodes cleanly, frame_cnt=1.
